// File: rtl/imm_pkg.sv
// Shared types and constants for the immediate-generation stage.
//   imm_fmt_e : immediate format reported alongside each decoded word
//   OPC_*     : RV32I base opcodes recognised by the decoder
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } imm_fmt_e;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: instruction word -> sign-extended immediate,
// format tag and illegal-opcode flag.
//   instr     : 32-bit instruction word
//   imm_c     : immediate sign-extended to XLEN (0 when the format is NONE)
//   fmt_c     : immediate format
//   illegal_c : opcode outside the RV32I base set
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm_c,
  output imm_fmt_e        fmt_c,
  output logic            illegal_c
);

  // Each arm builds the raw immediate as a signed vector; the width cast sign-extends it.
  always_comb begin
    imm_c     = '0;
    fmt_c     = FMT_NONE;
    illegal_c = 1'b0;
    case (instr[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
        fmt_c = FMT_I;
        imm_c = XLEN'($signed(instr[31:20]));
      end
      OPC_STORE: begin
        fmt_c = FMT_S;
        imm_c = XLEN'($signed({instr[31:25], instr[11:7]}));
      end
      OPC_BRANCH: begin
        fmt_c = FMT_B;
        imm_c = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt_c = FMT_U;
        imm_c = XLEN'($signed({instr[31:12], 12'b0}));
      end
      OPC_JAL: begin
        fmt_c = FMT_J;
        imm_c = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      end
      OPC_OP, OPC_MISC_MEM, OPC_SYSTEM: begin
        fmt_c = FMT_NONE;
      end
      default: begin
        illegal_c = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered, handshaked immediate-generation stage between fetch and execute.
// Decodes the immediate at push time, adds it to the pc, and holds results in a
// small FIFO skid buffer whose head drives the out_* ports.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : producer handshake carrying in_instr and in_pc
//   out_valid/out_ready   : consumer handshake
//   out_imm, out_fmt      : decoded immediate and its format
//   out_target            : in_pc + out_imm modulo 2^XLEN
//   out_illegal           : opcode not in the RV32I base set
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output imm_fmt_e        out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    imm_fmt_e        fmt;
    logic            illegal;
    logic [XLEN-1:0] target;
  } entry_t;

  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_illegal;
  entry_t          new_entry;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   wr_idx;
  logic            valid_q, valid_d;
  logic            rdy_q, rdy_d;
  logic            push, pop;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr     (in_instr),
    .imm_c     (dec_imm),
    .fmt_c     (dec_fmt),
    .illegal_c (dec_illegal)
  );

  // Result computed once at push; carry out of the adder is discarded.
  always_comb begin
    new_entry.imm     = dec_imm;
    new_entry.fmt     = dec_fmt;
    new_entry.illegal = dec_illegal;
    new_entry.target  = in_pc + dec_imm;
  end

  // With DEPTH=2 in_ready comes straight from a flop; with DEPTH=1 the single
  // entry may be refilled in the same cycle it is drained. rdy_q also stays low
  // during reset and rises on the first clock after release.
  if (DEPTH == 1) begin : g_ready_comb
    assign in_ready = rdy_q && (!valid_q || out_ready);
  end else begin : g_ready_reg
    assign in_ready = rdy_q;
  end

  assign push = in_valid && in_ready;
  assign pop  = valid_q && out_ready;

  // Shift-register FIFO: entry 0 is always the head; a push lands just behind
  // the last entry that survives this cycle's pop.
  always_comb begin
    mem_d   = mem_q;
    wr_idx  = count_q - CW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
    if (pop) begin
      for (int i = 1; i < int'(DEPTH); i++) begin
        mem_d[i-1] = mem_q[i];
      end
    end
    if (push) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (wr_idx == CW'(i)) begin
          mem_d[i] = new_entry;
        end
      end
    end
    valid_d = (count_d != '0);
    if (DEPTH == 1) begin
      rdy_d = 1'b1;
    end else begin
      rdy_d = (count_d < CW'(DEPTH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      count_q <= '0;
      valid_q <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
      valid_q <= valid_d;
      rdy_q   <= rdy_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_imm     = mem_q[0].imm;
  assign out_fmt     = mem_q[0].fmt;
  assign out_target  = mem_q[0].target;
  assign out_illegal = mem_q[0].illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Self-checking bench for imm_gen_stage: table-driven format vectors streamed
// through a scoreboard, plus hand-written backpressure, push+pop, reset and
// XLEN=64 sequences.
module tb_imm_gen_stage;
  import imm_pkg::*;

  typedef struct {
    logic [31:0] imm;
    imm_fmt_e    fmt;
    logic        ill;
    logic [31:0] target;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    exp_t        e;
  } vec_t;

  logic        clk, rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr, in_pc, out_imm, out_target;
  imm_fmt_e    out_fmt;

  logic        in_valid64, in_ready64, out_valid64, out_ready64, out_illegal64;
  logic [31:0] in_instr64;
  logic [63:0] in_pc64, out_imm64, out_target64;
  imm_fmt_e    out_fmt64;

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];
  exp_t cur_exp;

  imm_gen_stage #(.XLEN(32), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
    .out_target(out_target), .out_illegal(out_illegal)
  );

  imm_gen_stage #(.XLEN(64), .DEPTH(2)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_instr(in_instr64), .in_pc(in_pc64),
    .out_valid(out_valid64), .out_ready(out_ready64), .out_imm(out_imm64), .out_fmt(out_fmt64),
    .out_target(out_target64), .out_illegal(out_illegal64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference decode written with arithmetic shifts and masks.
  function automatic exp_t model(logic [31:0] ins, logic [31:0] pc);
    exp_t e;
    logic signed [31:0] s;
    logic [31:0] sh20, sh19, sh11;
    s    = ins;
    sh20 = s >>> 20;
    sh19 = s >>> 19;
    sh11 = s >>> 11;
    e.imm = '0; e.fmt = FMT_NONE; e.ill = 1'b0;
    case (ins[6:0])
      7'h03, 7'h13, 7'h67: begin e.fmt = FMT_I; e.imm = sh20; end
      7'h23: begin e.fmt = FMT_S; e.imm = (sh20 & ~32'h1F) | {27'b0, ins[11:7]}; end
      7'h63: begin
        e.fmt = FMT_B;
        e.imm = (sh19 & ~32'hFFF) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      end
      7'h37, 7'h17: begin e.fmt = FMT_U; e.imm = ins & 32'hFFFFF000; end
      7'h6F: begin
        e.fmt = FMT_J;
        e.imm = (sh11 & ~32'hFFFFF) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      end
      7'h33, 7'h0F, 7'h73: e.fmt = FMT_NONE;
      default: e.ill = 1'b1;
    endcase
    e.target = pc + e.imm;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One clock: observe both handshakes just before the edge, score the output
  // side, record the input side, and return at the next falling edge.
  task automatic cycle(output bit acc);
    bit fin, fout;
    exp_t e;
    #1;
    fin  = in_valid && in_ready;
    fout = out_valid && out_ready;
    acc  = fin;
    if (fout) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got imm=%h tgt=%h with no word pending", out_imm, out_target);
      end else begin
        e = sb_q.pop_front();
        if (out_imm !== e.imm || out_fmt !== e.fmt || out_illegal !== e.ill || out_target !== e.target) begin
          errors++;
          $display("FAIL sb_word: got imm=%h fmt=%0d ill=%b tgt=%h expected imm=%h fmt=%0d ill=%b tgt=%h",
                   out_imm, out_fmt, out_illegal, out_target, e.imm, e.fmt, e.ill, e.target);
        end
      end
    end
    if (fin) sb_q.push_back(cur_exp);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc, input exp_t e);
    bit acc;
    in_valid = 1'b1; in_instr = ins; in_pc = pc; cur_exp = e;
    acc = 1'b0;
    for (int n = 0; n < 50 && !acc; n++) cycle(acc);
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: instr %h not accepted", ins);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < 20 && sb_q.size() != 0; n++) cycle(acc);
    chk("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  vec_t vecs[10];
  logic [6:0] opcs[8];

  initial begin
    logic [31:0] r, w;
    exp_t e1;
    bit acc;

    vecs[0] = '{32'hFE010EE3, 32'h00000100, '{32'hFFFFFFFC, FMT_B,    1'b0, 32'h000000FC}};
    vecs[1] = '{32'h800000EF, 32'h00000200, '{32'hFFF00000, FMT_J,    1'b0, 32'hFFF00200}};
    vecs[2] = '{32'hFFF00093, 32'h00000000, '{32'hFFFFFFFF, FMT_I,    1'b0, 32'hFFFFFFFF}};
    vecs[3] = '{32'h12345037, 32'h00001000, '{32'h12345000, FMT_U,    1'b0, 32'h12346000}};
    vecs[4] = '{32'h0000007F, 32'h00000004, '{32'h00000000, FMT_NONE, 1'b1, 32'h00000004}};
    vecs[5] = '{32'h00000033, 32'h00000008, '{32'h00000000, FMT_NONE, 1'b0, 32'h00000008}};
    vecs[6] = '{32'h0080006F, 32'hFFFFFFFC, '{32'h00000008, FMT_J,    1'b0, 32'h00000004}};
    vecs[7] = '{32'hFE000E23, 32'h00000040, '{32'hFFFFFFFC, FMT_S,    1'b0, 32'h0000003C}};
    vecs[8] = '{32'h00C00067, 32'h00000010, '{32'h0000000C, FMT_I,    1'b0, 32'h0000001C}};
    vecs[9] = '{32'h00001017, 32'h00000010, '{32'h00001000, FMT_U,    1'b0, 32'h00001010}};
    opcs = '{7'h03, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h13, 7'h33, 7'h7B};

    // Reset held with random inputs.
    rst_n = 1'b0;
    in_valid64 = 1'b0; out_ready64 = 1'b1; in_instr64 = '0; in_pc64 = '0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'($urandom); out_ready = 1'($urandom);
      in_instr = $urandom; in_pc = $urandom;
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    chk("rel_out_valid", 64'(out_valid), 64'd0);
    chk("rel_out_imm", 64'(out_imm), 64'd0);
    chk("rel_out_fmt", 64'(out_fmt), 64'(FMT_NONE));
    chk("rel_out_target", 64'(out_target), 64'd0);
    chk("rel_out_illegal", 64'(out_illegal), 64'd0);

    // Format table streamed back-to-back with out_ready=1.
    for (int i = 0; i < 10; i++) send(vecs[i].instr, vecs[i].pc, vecs[i].e);
    drain();

    // Backpressure: two words fill the buffer, the third is held off.
    out_ready = 1'b0;
    e1 = model(32'hFFF00093, 32'h20);
    send(32'hFFF00093, 32'h20, e1);
    send(32'h12345037, 32'h24, model(32'h12345037, 32'h24));
    in_valid = 1'b1; in_instr = 32'hFE010EE3; in_pc = 32'h28;
    cur_exp = model(32'hFE010EE3, 32'h28);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("full_in_ready", 64'(in_ready), 64'd0);
      chk("full_head_stable", {out_valid, 31'b0, out_imm}, {1'b1, 31'b0, e1.imm});
      cycle(acc);
      if (acc) chk("full_accepted", 64'd1, 64'd0);
    end
    out_ready = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 10 && !acc; n++) cycle(acc);
    chk("bp_third_accepted", 64'(acc), 64'd1);
    drain();

    // Steady push+pop at occupancy 1.
    out_ready = 1'b0;
    send(32'h00500113, 32'h300, model(32'h00500113, 32'h300));
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      r = $urandom;
      w = {r[31:7], opcs[k % 8]};
      in_valid = 1'b1; in_instr = w; in_pc = 32'h400 + 32'(k * 4);
      cur_exp = model(w, in_pc);
      #1;
      chk("pp_occupancy", {62'b0, in_ready && out_valid, 1'(sb_q.size() == 1)}, 64'd3);
      cycle(acc);
    end
    drain();

    // Reset asserted with two words buffered.
    out_ready = 1'b0;
    send(32'h00000013, 32'h500, model(32'h00000013, 32'h500));
    send(32'h00000013, 32'h504, model(32'h00000013, 32'h504));
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out_target", 64'(out_target), 64'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // XLEN=64 sign extension and wrap.
    in_valid64 = 1'b1; in_instr64 = 32'h80000037; in_pc64 = 64'h0;
    @(negedge clk);
    in_instr64 = 32'h0080006F; in_pc64 = 64'hFFFF_FFFF_FFFF_FFFC;
    chk("x64_lui_valid", 64'(out_valid64), 64'd1);
    chk("x64_lui_imm", out_imm64, 64'hFFFF_FFFF_8000_0000);
    chk("x64_lui_fmt", 64'(out_fmt64), 64'(FMT_U));
    @(negedge clk);
    in_valid64 = 1'b0;
    chk("x64_jal_imm", out_imm64, 64'h8);
    chk("x64_jal_target", out_target64, 64'h4);
    @(negedge clk);
    chk("x64_empty", 64'(out_valid64), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
